// File: rtl/mul_issue_pipe_pkg.sv
// Shared definitions for the multiply issue pipe: op encoding and per-op
// operand signedness used by the high-word correction.
package mul_pkg;

  localparam int MUL_OP_W = 2;

  typedef enum logic [MUL_OP_W-1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  // Returns {a_signed, b_signed}; MUL takes the low word so signedness is moot.
  function automatic logic [1:0] mul_op_signs(input logic [MUL_OP_W-1:0] op);
    logic [1:0] s;
    case (op)
      MUL_OP_MULH:   s = 2'b11;
      MUL_OP_MULHSU: s = 2'b10;
      default:       s = 2'b00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mul_issue_pipe_booth.sv
// Combinational radix-4 Booth multiplier producing the unsigned 64-bit
// product of two 32-bit operands.
module booth_multiplier (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_p
);

  logic [63:0] w_a64;
  logic [34:0] w_bx;
  logic [63:0] w_acc;
  logic [63:0] w_pp;
  logic [2:0]  w_trip;

  // Two zero bits on top keep the recoding unsigned; the low zero is b[-1].
  assign w_a64 = {32'b0, i_a};
  assign w_bx  = {2'b00, i_b, 1'b0};

  always_comb begin
    w_acc  = '0;
    w_pp   = '0;
    w_trip = '0;
    for (int i = 0; i < 17; i++) begin
      w_trip = w_bx[2*i +: 3];
      case (w_trip)
        3'b001, 3'b010: w_pp = w_a64;
        3'b011:         w_pp = w_a64 << 1;
        3'b100:         w_pp = -(w_a64 << 1);
        3'b101, 3'b110: w_pp = -w_a64;
        default:        w_pp = '0;
      endcase
      w_acc = w_acc + (w_pp << (2*i));
    end
  end

  assign o_p = w_acc;

endmodule

// File: rtl/mul_issue_pipe.sv
// Two-stage multiply pipe: S1 holds operands feeding the Booth core, S2 holds
// the selected/corrected result word and tag driving the outputs.
module mul_issue_pipe
  import mul_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MUL_OP_W-1:0] in_op,
  input  logic [31:0]         in_a,
  input  logic [31:0]         in_b,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_result,
  output logic [TAG_W-1:0]    out_tag
);

  logic                r_s1_valid;
  logic [31:0]         r_s1_a;
  logic [31:0]         r_s1_b;
  logic [MUL_OP_W-1:0] r_s1_op;
  logic [TAG_W-1:0]    r_s1_tag;

  logic                r_s2_valid;
  logic [31:0]         r_s2_result;
  logic [TAG_W-1:0]    r_s2_tag;

  logic                w_adv;
  logic [63:0]         w_p;
  logic [1:0]          w_signs;
  logic [31:0]         w_corr_a;
  logic [31:0]         w_corr_b;
  logic [31:0]         w_hi;
  logic [31:0]         w_res;

  assign w_adv    = !r_s2_valid || out_ready;
  assign in_ready = w_adv && !flush;

  booth_multiplier u_booth (
    .i_a (r_s1_a),
    .i_b (r_s1_b),
    .o_p (w_p)
  );

  // Signed high word from the unsigned product: subtract the other operand
  // for each operand whose sign bit carries weight -2^31 rather than +2^31.
  assign w_signs  = mul_op_signs(r_s1_op);
  assign w_corr_a = (w_signs[1] && r_s1_a[31]) ? r_s1_b : 32'd0;
  assign w_corr_b = (w_signs[0] && r_s1_b[31]) ? r_s1_a : 32'd0;
  assign w_hi     = w_p[63:32] - w_corr_a - w_corr_b;
  assign w_res    = (r_s1_op == MUL_OP_MUL) ? w_p[31:0] : w_hi;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_tag    <= '0;
    end else begin
      if (w_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_result <= w_res;
          r_s2_tag    <= r_s1_tag;
        end
        r_s1_valid <= in_valid;
        if (in_valid && !flush) begin
          r_s1_a   <= in_a;
          r_s1_b   <= in_b;
          r_s1_op  <= in_op;
          r_s1_tag <= in_tag;
        end
      end
      if (flush) begin
        r_s1_valid <= 1'b0;
        r_s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_result = r_s2_result;
  assign out_tag    = r_s2_tag;

endmodule

// File: tb/tb_mul_issue_pipe.sv
// Directed bench for mul_issue_pipe: latency, corner products, backpressure,
// flush and mid-stream reset, with hand-computed expectations.
module tb_mul_issue_pipe;
  import mul_pkg::*;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;

  int checks   = 0;
  int failures = 0;

  mul_issue_pipe #(.TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = MUL_OP_MUL; in_a = '0; in_b = '0; in_tag = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_result !== 32'h0) begin failures++; $display("FAIL reset_out_result got=%h exp=0", out_result); end
    checks++; if (out_tag !== 4'h0) begin failures++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
  endtask

  task automatic test_mul_latency();
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = MUL_OP_MUL; in_a = 32'd7; in_b = 32'd6; in_tag = 4'd5;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL lat_in_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_early_valid got=%b exp=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL lat_out_valid got=%b exp=1", out_valid); end
    checks++; if (out_result !== 32'd42) begin failures++; $display("FAIL lat_result got=%0d exp=42", out_result); end
    checks++; if (out_tag !== 4'd5) begin failures++; $display("FAIL lat_tag got=%0d exp=5", out_tag); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_all_ones();
    logic [1:0]  ops [3];
    logic [31:0] exp [3];
    ops[0] = MUL_OP_MULH;  exp[0] = 32'h0000_0000;
    ops[1] = MUL_OP_MULHU; exp[1] = 32'hFFFF_FFFE;
    ops[2] = MUL_OP_MUL;   exp[2] = 32'h0000_0001;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c < 3) begin
        in_valid = 1'b1; in_op = ops[c]; in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF;
        in_tag = 4'(c + 8);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (c >= 1) begin
        checks++;
        if (out_valid !== 1'b1 || out_result !== exp[c-1] || out_tag !== 4'(c + 7)) begin
          failures++;
          $display("FAIL ones_op%0d got v=%b r=%h t=%0d exp v=1 r=%h t=%0d",
                   c - 1, out_valid, out_result, out_tag, exp[c-1], c + 7);
        end
      end
    end
    tick();
  endtask

  task automatic test_signed_corners();
    logic [1:0]  ops [2];
    logic [31:0] as  [2];
    logic [31:0] bs  [2];
    logic [31:0] exp [2];
    ops[0] = MUL_OP_MULHSU; as[0] = 32'h8000_0000; bs[0] = 32'hFFFF_FFFF; exp[0] = 32'h8000_0000;
    ops[1] = MUL_OP_MULH;   as[1] = 32'h8000_0000; bs[1] = 32'h8000_0000; exp[1] = 32'h4000_0000;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c < 2) begin
        in_valid = 1'b1; in_op = ops[c]; in_a = as[c]; in_b = bs[c]; in_tag = 4'(c + 2);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (c >= 1) begin
        checks++;
        if (out_valid !== 1'b1 || out_result !== exp[c-1]) begin
          failures++;
          $display("FAIL corner%0d got v=%b r=%h exp v=1 r=%h", c - 1, out_valid, out_result, exp[c-1]);
        end
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got = 0;
    int stall_left = -1;
    logic [31:0] held_r = '0;
    logic [3:0]  held_t = '0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      if (stall_left < 0 && out_valid) begin
        stall_left = 3; held_r = out_result; held_t = out_tag;
      end
      out_ready = !(stall_left > 0);
      in_valid  = (sent < 4);
      in_op = MUL_OP_MUL; in_a = 32'(sent + 1); in_b = 32'd3; in_tag = 4'(sent + 1);
      #1;
      if (stall_left > 0) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== held_r || out_tag !== held_t) begin
          failures++;
          $display("FAIL bp_hold got rdy=%b v=%b r=%h t=%0d exp rdy=0 v=1 r=%h t=%0d",
                   in_ready, out_valid, out_result, out_tag, held_r, held_t);
        end
        stall_left--;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (out_tag !== 4'(got + 1) || out_result !== 32'(3 * (got + 1))) begin
          failures++;
          $display("FAIL bp_order got t=%0d r=%0d exp t=%0d r=%0d", out_tag, out_result, got + 1, 3 * (got + 1));
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (got != 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", got); end
    tick(); tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = MUL_OP_MUL; in_a = 32'd5; in_b = 32'd5; in_tag = 4'd1;
    tick();
    in_a = 32'd2; in_b = 32'd3; in_tag = 4'd2;
    tick();
    flush = 1'b1; in_a = 32'd9; in_b = 32'd9; in_tag = 4'd3;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_accept got=%b exp=0", out_valid); end
    in_valid = 1'b1; in_a = 32'd7; in_b = 32'd3; in_tag = 4'd4;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_next_early got=%b exp=0", out_valid); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd21 || out_tag !== 4'd4) begin
      failures++;
      $display("FAIL flush_next got v=%b r=%0d t=%0d exp v=1 r=21 t=4", out_valid, out_result, out_tag);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = MUL_OP_MULHU; in_a = 32'hFFFF_FFFF; in_b = 32'd16; in_tag = 4'd6;
    tick();
    in_tag = 4'd7;
    tick();
    rst = 1'b1; in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_result !== 32'h0 || out_tag !== 4'h0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid got v=%b r=%h t=%0d rdy=%b exp v=0 r=0 t=0 rdy=1",
               out_valid, out_result, out_tag, in_ready);
    end
    rst = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_s1 got=%b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_mul_latency();
    test_all_ones();
    test_signed_corners();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_issue_pipe.md
# mul_issue_pipe

Two-stage pipelined multiply unit that wraps the combinational `booth_multiplier` core with a valid/ready handshake. It accepts RISC-V M-extension style multiply requests (MUL, MULH, MULHSU, MULHU) and registers operands in front of the core. It applies signed high-word correction to the core's unsigned 64-bit product and returns a registered 32-bit result with a pass-through tag. It sits between the execute-stage issue logic and writeback.

## Interface
- `TAG_W`, default 4: width of the opaque request tag carried alongside each operation.
- `clk` input 1: sole clock; every register updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `flush` input 1: synchronous kill of all in-flight operations.
- `in_valid` input 1: request present.
- `in_ready` output 1: request accepted on an edge where `in_valid && in_ready`.
- `in_op` input 2: operation code.
  - 00 = MUL (low word).
  - 01 = MULH (signed×signed, high word).
  - 10 = MULHSU (signed a × unsigned b, high word).
  - 11 = MULHU (unsigned×unsigned, high word).
- `in_a` input 32: multiplicand.
- `in_b` input 32: multiplier.
- `in_tag` input TAG_W: request tag.
- `out_valid` output 1: result present.
- `out_ready` input 1: consumer accepts the result on an edge where `out_valid && out_ready`.
- `out_result` output 32: selected, corrected result word.
- `out_tag` output TAG_W: tag of the result.

## Operation
- **S1 registers:** `s1_valid`, `s1_a`, `s1_b`, `s1_op`, `s1_tag`.
- **Core:** the `booth_multiplier` core is driven combinationally from the S1 registers. It yields P, the unsigned 64-bit product of `s1_a` and `s1_b`.
- **Low word:** MUL returns P[31:0], with no correction.
- **High-word correction**, computed modulo 2^32: hi = P[63:32] − (a_signed & a[31] ? b : 0) − (b_signed & b[31] ? a : 0).
  - MULH: a_signed = 1, b_signed = 1.
  - MULHSU: a_signed = 1, b_signed = 0.
  - MULHU: a_signed = 0, b_signed = 0.
- **S2 registers:** `s2_valid`, `s2_result` (selected or corrected word), `s2_tag`. The S2 registers drive the outputs directly.
- **Pipeline advance:** `adv = !s2_valid || out_ready`.
  - S1 and S2 advance in lockstep when `adv` is high and hold when it is low.
  - When `adv` is high:
    - S2 loads `s1_valid` and the S1-derived data.
    - S1 loads `in_valid` and the input fields.
- **Input handshake:** `in_ready = adv && !flush`. It depends only on `s2_valid`, `out_ready` and `flush`, never on `in_valid`.
- **Data registers on bubbles:** data registers load only when their stage's incoming valid is 1. Otherwise they hold their previous value.
- **Flush:**
  - On an edge with `flush = 1`, `s1_valid` and `s2_valid` clear.
  - Any same-cycle input is not accepted (`in_ready = 0`).
  - A result being handed off with `out_ready = 1` on that edge counts as delivered.
- **Reset:**
  - Clears `s1_valid` and `s2_valid`, and zeroes `s2_result` and `s2_tag`.
  - Reset mid-operation discards all in-flight operations.
  - Reset takes precedence over `flush` and over the handshakes.

## Timing
- **Latency:** a request accepted at edge N shows `out_valid = 1` with its result after edge N+1, i.e. 2 cycles.
- **Throughput:** 1 operation per cycle when `out_ready` is held high.
- **Backpressure:** with `out_valid = 1` and `out_ready = 0`:
  - `in_ready` is 0.
  - `out_result` and `out_tag` stay stable until the handshake completes.
  - S1 holds its contents.
- **Ordering:** strictly in order; no operation is dropped or duplicated except by `flush` or `rst`.
- **Critical path:** the booth core plus the correction subtract, between the S1 and S2 registers.
- **Output values after reset:** `in_ready = 1`, `out_valid = 0`, `out_result = 0`, `out_tag = 0`.

## Structure
- **Shared package `mul_pkg`:**
  - The op codes `MUL_OP_MUL`, `MUL_OP_MULH`, `MUL_OP_MULHSU`, `MUL_OP_MULHU`.
  - The 2-bit op width constant.
  - A function returning (a_signed, b_signed) per op, reused by issue logic and the bench model.
- **Sub-modules:**
  - The only sub-module is the existing `booth_multiplier`, instantiated once.
  - The correction and word select are inline combinational logic.

## Test plan
- **MUL latency:** MUL a = 7, b = 6, `out_ready` = 1. `out_result` = 42 exactly two cycles after acceptance, tag echoed.
- **All-ones operands:** a = b = 0xFFFFFFFF.
  - MULH gives 0x00000000.
  - MULHU gives 0xFFFFFFFE.
  - MUL gives 0x00000001.
- **Signed high-word corners:**
  - MULHSU with a = 0x80000000, b = 0xFFFFFFFF gives 0x80000000.
  - MULH with a = b = 0x80000000 gives 0x40000000.
- **Backpressure:** back-to-back stream of tags 1–4 with `out_ready` low for 3 cycles after the first result.
  - `in_ready` drops while `out_valid && !out_ready`.
  - The held result stays stable.
  - All four results emerge in tag order, none lost.
- **Flush:** `flush` asserted while two operations are in flight, with `in_valid` high.
  - `out_valid` is 0 the next cycle.
  - The concurrent input is not accepted.
  - The next request afterwards completes normally in 2 cycles.
- **Reset mid-stream:** `rst` asserted mid-stream. The next cycle shows `out_valid` = 0, `out_result` = 0, `out_tag` = 0, `in_ready` = 1.
